// File: rtl/serial_adder_acc.sv
// LSB-first add/sub/accumulate engine, STEP bits per cycle through a registered carry.
// Start accepted in IDLE -> done pulse WIDTH/STEP active cycles later; ena=0 freezes all state.
module serial_adder_acc #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d, acc_q, acc_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             done_q, done_d, acc_upd_q, acc_upd_d;

    logic [STEP:0]    c;
    logic [STEP-1:0]  s;
    logic [WIDTH-1:0] res_next;

    // Ripple the STEP low-order bits of X/Y; c[STEP-1] is the carry into the chunk MSB.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carry_q;
        for (int i = 0; i < STEP; i++) begin
            s[i]   = x_q[i] ^ y_q[i] ^ c[i];
            c[i+1] = (x_q[i] & y_q[i]) | (c[i] & (x_q[i] ^ y_q[i]));
        end
        res_next = (res_q >> STEP) | (WIDTH'(s) << (WIDTH - STEP));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        sum_d     = sum_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        acc_upd_d = acc_upd_q;
        if (ena_i) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_upd_d = 1'b0;
                        carry_d   = 1'b0;
                        cnt_d     = '0;
                        state_d   = RUN;
                        case (mode_i)
                            2'b00: begin
                                x_d = a_i;
                                y_d = b_i;
                            end
                            2'b01: begin
                                x_d     = a_i;
                                y_d     = ~b_i;
                                carry_d = 1'b1;
                            end
                            2'b10: begin
                                x_d       = acc_q;
                                y_d       = a_i;
                                acc_upd_d = 1'b1;
                            end
                            default: begin
                                acc_d   = '0;
                                sum_d   = '0;
                                cout_d  = 1'b0;
                                ovf_d   = 1'b0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
                RUN: begin
                    x_d     = x_q >> STEP;
                    y_d     = y_q >> STEP;
                    carry_d = c[STEP];
                    res_d   = res_next;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(NSTEPS - 1)) begin
                        sum_d   = res_next;
                        cout_d  = c[STEP];
                        ovf_d   = c[STEP-1] ^ c[STEP];
                        if (acc_upd_q) acc_d = res_next;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            acc_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            acc_upd_q <= acc_upd_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign busy_o = (state_q == RUN);
    assign done_o = done_q;

endmodule
